// File: rtl/parallel_to_serial.sv
// parallel_to_serial: valid/ready loaded shift-register serializer with frame_start and serial_valid.
// Define SERIAL_PARITY_EN to append an even-parity bit after each word's data bits.
module parallel_to_serial #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef SERIAL_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    logic par, par_d;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif
    state_t state, state_d;
    logic [WIDTH-1:0] sreg, sreg_d, shifted;
    logic [CW-1:0] bcnt, bcnt_d;
    logic so_d, sv_d, fs_d, accept, last;
    function automatic logic first_bit(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction
    assign last    = (bcnt == LAST);
    assign shifted = (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);
    assign busy    = (state != IDLE);
`ifdef SERIAL_PARITY_EN
    assign load_ready = (state == IDLE) || (state == PARITY);
`else
    assign load_ready = (state == IDLE) || ((state == SHIFT) && last);
`endif
    assign accept = load_valid && load_ready;
    // serial_out is loaded with the bit that sreg will present, keeping it a true flop output
    always_comb begin
        state_d = state;
        sreg_d  = sreg;
        bcnt_d  = bcnt;
        so_d    = 1'b0;
        sv_d    = 1'b0;
        fs_d    = 1'b0;
`ifdef SERIAL_PARITY_EN
        par_d   = par;
`endif
        if (accept) begin
            state_d = SHIFT;
            sreg_d  = parallel_in;
            bcnt_d  = '0;
            so_d    = first_bit(parallel_in);
            sv_d    = 1'b1;
            fs_d    = 1'b1;
`ifdef SERIAL_PARITY_EN
            par_d   = ^parallel_in;
`endif
        end else if (state == SHIFT) begin
            sreg_d = shifted;
            if (!last) begin
                bcnt_d = bcnt + 1'b1;
                so_d   = first_bit(shifted);
                sv_d   = 1'b1;
            end else begin
                bcnt_d = '0;
`ifdef SERIAL_PARITY_EN
                state_d = PARITY;
                so_d    = par;
                sv_d    = 1'b1;
`else
                state_d = IDLE;
`endif
            end
        end
`ifdef SERIAL_PARITY_EN
        else if (state == PARITY) begin
            state_d = IDLE;
        end
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sreg         <= '0;
            bcnt         <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
`ifdef SERIAL_PARITY_EN
            par          <= 1'b0;
`endif
        end else begin
            state        <= state_d;
            sreg         <= sreg_d;
            bcnt         <= bcnt_d;
            serial_out   <= so_d;
            serial_valid <= sv_d;
            frame_start  <= fs_d;
`ifdef SERIAL_PARITY_EN
            par          <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_parallel_to_serial.sv
// tb_parallel_to_serial: scoreboard bench driving an MSB-first and an LSB-first serializer in lockstep.
module tb_parallel_to_serial;
`ifdef SERIAL_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = 4 + PAR;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] pi = '0;
    logic lv = 1'b0;
    logic rdy_a, so_a, sv_a, fs_a, busy_a;
    logic rdy_b, so_b, sv_b, fs_b, busy_b;
    logic [1:0] qa[$];
    logic [1:0] qb[$];
    logic [1:0] e;
    int total = 0;
    int bad = 0;
    int waited;
    always #5 clk = ~clk;
    parallel_to_serial #(.WIDTH(4), .MSB_FIRST(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .parallel_in(pi), .load_valid(lv), .load_ready(rdy_a),
        .serial_out(so_a), .serial_valid(sv_a), .frame_start(fs_a), .busy(busy_a)
    );
    parallel_to_serial #(.WIDTH(4), .MSB_FIRST(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .parallel_in(pi), .load_valid(lv), .load_ready(rdy_b),
        .serial_out(so_b), .serial_valid(sv_b), .frame_start(fs_b), .busy(busy_b)
    );
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask
    // each queue entry is {frame_start, serial_out}
    task automatic push(input logic [3:0] w);
        for (int i = 0; i < 4; i++) begin
            qa.push_back({i == 0, w[3-i]});
            qb.push_back({i == 0, w[i]});
        end
        if (PAR != 0) begin
            qa.push_back({1'b0, ^w});
            qb.push_back({1'b0, ^w});
        end
    endtask
    task automatic send(input logic [3:0] w, output int n);
        push(w);
        pi = w;
        lv = 1'b1;
        n = 0;
        while (!rdy_a && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_bound", n < 40, 1);
        @(posedge clk); #1;
    endtask
    task automatic drain();
        int n;
        lv = 1'b0;
        n = 0;
        while ((busy_a || busy_b || qa.size() != 0 || qb.size() != 0) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_bound", n < 60, 1);
    endtask
    always @(negedge clk) begin
        if (sv_a) begin
            chk("a_queue_nonempty", qa.size() != 0, 1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("a_bit", {fs_a, so_a}, e);
            end
        end else chk("a_idle_out", {fs_a, so_a}, 0);
        if (sv_b) begin
            chk("b_queue_nonempty", qb.size() != 0, 1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("b_bit", {fs_b, so_b}, e);
            end
        end else chk("b_idle_out", {fs_b, so_b}, 0);
        chk("a_busy_vs_valid", busy_a, sv_a);
        chk("b_busy_vs_valid", busy_b, sv_b);
    end
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        #12;
        chk("rst_outputs_a", {so_a, sv_a, fs_a, busy_a}, 0);
        chk("rst_ready_a", rdy_a, 1);
        chk("rst_ready_b", rdy_b, 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        // single frame: ready profile across the frame and the idle cycle after it
        send(4'b1011, waited);
        lv = 1'b0;
        for (int k = 1; k <= NB + 1; k++) begin
            chk("frame_ready_a", rdy_a, k >= NB);
            chk("frame_ready_b", rdy_b, k >= NB);
            chk("frame_busy", busy_a, k <= NB);
            @(posedge clk); #1;
        end
        drain();
        // streaming: second word taken on the last cycle of the first
        send(4'hA, waited);
        send(4'h5, waited);
        chk("stream_wait", waited, NB - 1);
        drain();
        // backpressure: request raised on bit 2 waits for the ready cycle
        send(4'h6, waited);
        lv = 1'b0;
        @(posedge clk); #1;
        send(4'hF, waited);
        chk("backpressure_wait", waited, NB - 2);
        drain();
        send(4'b1001, waited);
        drain();
        // reset mid-frame drops the word
        send(4'hC, waited);
        lv = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs_a", {so_a, sv_a, fs_a, busy_a}, 0);
        chk("midrst_outputs_b", {so_b, sv_b, fs_b, busy_b}, 0);
        chk("midrst_ready", {rdy_a, rdy_b}, 2'b11);
        qa.delete();
        qb.delete();
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", {busy_a, busy_b}, 0);
        send(4'h3, waited);
        drain();
        for (int i = 0; i < 6; i++) send(4'($urandom_range(0, 15)), waited);
        drain();
        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/parallel_to_serial.md
Name: parallel_to_serial

Overview:
Shift-register serializer. It accepts a parallel word through a valid/ready handshake and drives it out one bit per clock on a serial line. It marks each frame with a start pulse and a per-bit valid qualifier. This is the transmit end of the team's 4-bit serial link. Back-to-back words stream with no idle gap between frames.

Parameters:
WIDTH, 4, data word width in bits (must be >= 1)
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
parallel_in  input  WIDTH  word to transmit; sampled only on an accept
load_valid  input  1  producer has a word on parallel_in
load_ready  output  1  block can accept a word this cycle
serial_out  output  1  current serial bit (registered)
serial_valid  output  1  serial_out carries a frame bit this cycle (registered)
frame_start  output  1  one-cycle pulse coincident with the first bit of each frame (registered)
busy  output  1  high while a frame is in flight (state != IDLE)

Behaviour:
- One clock domain only. rst_n is asynchronous assert; all flops clear immediately on rst_n low.
- States:
  - IDLE: no frame in flight.
  - SHIFT: driving data bits.
- Internal registers:
  - Shift register sreg[WIDTH-1:0].
  - Bit counter bcnt, width $clog2(WIDTH+1). Counts 0..WIDTH-1 and never exceeds WIDTH-1.
- Reset values:
  - State IDLE; sreg 0; bcnt 0.
  - serial_out 0; serial_valid 0; frame_start 0; busy 0.
  - load_ready 1, because it is decoded from IDLE.
- load_ready is combinational: high in IDLE, or in SHIFT when bcnt == WIDTH-1 (last bit cycle). Low otherwise.
- Accept = load_valid && load_ready, evaluated at the rising edge. On accept:
  - sreg <= parallel_in; bcnt <= 0; state <= SHIFT.
  - First bit appears on serial_out the cycle after the accept edge (latency 1).
  - frame_start and serial_valid are high in that cycle.
- SHIFT, per cycle:
  - serial_out = sreg[WIDTH-1] if MSB_FIRST, else sreg[0]. Output is registered and reflects the sreg contents.
  - sreg shifts left by one when MSB_FIRST, otherwise right by one; zero fill.
  - bcnt increments.
- Last bit (bcnt == WIDTH-1):
  - With accept: reload. The next frame's first bit immediately follows, frame_start pulses again, and serial_valid stays high.
  - Without accept: state <= IDLE. Next cycle serial_valid = 0 and serial_out = 0.
- IDLE drives serial_out = 0 and serial_valid = 0.
- load_valid in a non-ready cycle has no effect. parallel_in is ignored, and the producer must hold it.
- WIDTH = 1: every frame is a single bit. load_ready is high continuously, and frame_start equals serial_valid for each accepted word.
- Reset mid-frame: the in-flight word is dropped. There is no partial-frame completion after release. The first cycle after release is IDLE.
- Throughput: one word per WIDTH cycles when sustained.

Optional Feature:
SERIAL_PARITY_EN
- Defined:
  - An even-parity bit (XOR of the accepted word) is appended after the data bits. It is captured at accept into a parity flop.
  - A PARITY state is added after SHIFT, so serial_valid covers WIDTH+1 cycles.
  - load_ready is high in IDLE and in the PARITY cycle. It is no longer high on the last data bit.
  - Back-to-back frames follow the parity bit with no gap.
- Undefined: no parity state and no parity flop; behaviour is exactly as above.
- Ports are identical in both builds.

Test Plan:
- Basic MSB-first (WIDTH=4, MSB_FIRST=1): one-cycle load_valid with parallel_in=4'b1011 from IDLE.
  - serial_out = 1,0,1,1 on cycles +1..+4 with serial_valid high; frame_start only on +1.
  - load_ready low on +1..+3, high on +4; cycle +5 idle with serial_out=0.
- LSB-first (MSB_FIRST=0): load 4'b1011 -> serial_out = 1,1,0,1; timing otherwise identical.
- Streaming: load_valid held with 4'hA then 4'h5 (second accepted on the last-bit cycle).
  - 8 contiguous bits 1,0,1,0,0,1,0,1 with serial_valid high for 8 cycles.
  - frame_start on bits 1 and 5; busy never drops between frames.
- Backpressure: assert load_valid with 4'hF mid-frame on bit 2. It is not accepted until the bit-4 cycle, and the original frame bits are unchanged.
- Reset mid-frame: pull rst_n low after 2 bits of 4'hC.
  - All outputs 0 immediately and load_ready 1.
  - After release, new word 4'h3 emits 0,0,1,1 cleanly.
- SERIAL_PARITY_EN defined: load 4'b1011 -> serial_out = 1,0,1,1,1 (parity 1) with serial_valid for 5 cycles; load 4'b1001 -> parity bit 0.
